axi_slv_mem: RTL and testbench
==============================

Name: axi_slv_mem

Overview:
- Synthesizable AXI3 slave responder backed by a word-addressed on-chip memory. It is the completing end of the AXI master interface used by the environment.
- Accepts write address, write data and read address bursts. Returns write responses and read data.
- Serves as the DUT-side target that the master agent drives in loopback and regression tests.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, width of wdata/rdata; 32 or 64.
- ID_WIDTH, 4, width of all ID fields.
- MEM_DEPTH, 256, number of DATA_WIDTH words; byte range is 0 to MEM_DEPTH*DATA_WIDTH/8-1.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- awid  in  ID_WIDTH  write address id
- awaddr  in  ADDR_WIDTH  write start byte address
- awlen  in  8  beats-1
- awsize  in  3  bytes per beat = 1<<awsize
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid  in  1 / awready  out  1
- wid  in  ID_WIDTH / wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8 / wlast  in  1
- wvalid  in  1 / wready  out  1
- bid  out  ID_WIDTH / bresp  out  2 / bvalid  out  1 / bready  in  1
- arid  in  ID_WIDTH / araddr  in  ADDR_WIDTH / arlen  in  8 / arsize  in  3 / arburst  in  2
- arvalid  in  1 / arready  out  1
- rid  out  ID_WIDTH / rdata  out  DATA_WIDTH / rresp  out  2 / rlast  out  1 / rvalid  out  1 / rready  in  1

Behaviour:
- Clocking and reset: one clock, aclk. Reset areset is asynchronous, active-high.
- While areset is high:
  - Write FSM goes to W_IDLE and read FSM goes to R_IDLE.
  - All outputs are 0, including awready and arready.
  - Memory contents are not reset.
- awready and arready are registered. Each rises on the first aclk edge after areset falls.
- Reset mid-burst abandons the burst. No response is issued and no further beats are written.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/size/burst, clear the error flag and beat count, then go to W_DATA. awready=0 outside W_IDLE.
  - W_DATA: wready=1. On each wvalid&wready:
    - Write the strobed bytes into word (addr/(DATA_WIDTH/8)) unless an error is flagged for that beat.
    - Advance the address and increment the beat count.
    - After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid, bresp=00 OKAY or 10 SLVERR. Hold until bready, then go to W_IDLE. awready is reasserted on the following edge.
- Read FSM:
  - R_IDLE: arready=1. On the handshake, latch the fields and go to R_DATA.
  - R_DATA: rvalid rises the cycle after the AR handshake.
  - rdata/rresp/rlast are registered and held stable while rvalid&!rready.
  - On rvalid&rready, load the next beat on the same edge. rvalid stays 1, giving back-to-back beats.
  - rlast=1 on beat arlen+1. Its handshake returns the FSM to R_IDLE with rvalid=0.
  - rid = latched arid on every beat.
- The write and read FSMs are fully independent and run concurrently.
- Same-edge write beat and read beat load of the same word: the read returns the old data (read-before-write).
- Address generation, with N = 1<<size:
  - INCR: next = (addr & ~(N-1)) + N. The first beat may be unaligned; later beats are aligned.
  - FIXED: address is unchanged.
  - WRAP: start must be N-aligned and len must be in {1,3,7,15}. Wrap boundary is (len+1)*N. The address wraps to the boundary-aligned base when it reaches base+(len+1)*N.
  - Address arithmetic is ADDR_WIDTH wide with no carry out.
- Error rules (SLVERR=10). The burst is fully accepted; only memory effects are suppressed.
  - Burst-wide errors: awburst/arburst=11, size > log2(DATA_WIDTH/8), or an illegal WRAP len/alignment. No beat is written and every read beat returns rdata=0.
  - Per-beat out-of-range (word index >= MEM_DEPTH): that beat is not written and the read beat returns rdata=0 with rresp=10. Write bresp becomes 10.
  - wid != latched awid on any beat: bresp=10, and the data is still written.
  - wlast mismatch (wlast=1 before the final beat or 0 on the final beat): bresp=10. The burst still ends on the slave's own count.
- bresp reports SLVERR if any error occurred during the burst. rresp is reported per beat.

Test Plan:
- INCR write awaddr=0x10, awlen=3, awsize=2, wdata=0xA0..0xA3, full strobes, then INCR read of the same range -> bresp=00 bid=awid; rdata 0xA0,0xA1,0xA2,0xA3 with rlast on the 4th beat only.
- WRAP read araddr=0x38, arlen=3, arsize=2 after preloading words 0x30..0x3C -> beat addresses 0x38,0x3C,0x30,0x34; all rresp=00.
- Partial strobe: write 0xDEADBEEF with wstrb=0101 at 0x0 over an existing 0x11223344 -> readback 0x11AD33EF.
- Out-of-range INCR write starting at the last valid word, awlen=1 -> first beat written, second dropped, bresp=10; read of the same burst gives rresp 00 then 10, with rdata 0 on the 2nd beat.
- Backpressure: rready toggled 1,0,0,1 and bready held low 5 cycles -> rdata/rlast stable while stalled; bvalid held; no AW accepted until B completes.
- Assert areset mid write burst (after 2 of 4 beats) -> all outputs 0 asynchronously; no bvalid afterwards; the 2 written words persist; awready=1 one edge after release.

Source files
------------

// File: rtl/axi_slv_mem_if.sv
// axi_slv_mem_if
//   AXI3 signal bundle connecting a master agent to the axi_slv_mem responder.
//   Channels:
//     AW : awid, awaddr, awlen, awsize, awburst, awvalid / awready
//     W  : wid, wdata, wstrb, wlast, wvalid / wready
//     B  : bid, bresp, bvalid / bready
//     AR : arid, araddr, arlen, arsize, arburst, arvalid / arready
//     R  : rid, rdata, rresp, rlast, rvalid / rready
//   Modports: slave (responder view), master (initiator view).
interface axi_slv_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slv_mem.sv
// axi_slv_mem
//   AXI3 slave responder backed by a word-addressed on-chip memory of
//   MEM_DEPTH words of DATA_WIDTH bits. Independent write (AW/W/B) and read
//   (AR/R) engines run concurrently. Illegal bursts and out-of-range beats are
//   fully accepted but have their memory effects suppressed and report SLVERR.
//   Ports:
//     aclk   : clock
//     areset : asynchronous active-high reset (FSMs and outputs, not memory)
//     bus    : axi_slv_mem_if.slave, all five AXI channels
module axi_slv_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic          aclk,
    input  logic          areset,
    axi_slv_mem_if.slave  bus
);
    localparam int         BYTES    = DATA_WIDTH / 8;
    localparam int         OFF      = $clog2(BYTES);
    localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] SIZE_MAX = 3'(OFF);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Bytes per beat for a given size code.
    function automatic logic [ADDR_WIDTH-1:0] beat_bytes(input logic [2:0] size);
        return ADDR_WIDTH'(1) << size;
    endfunction

    // Address of the beat following addr. INCR aligns after the first beat;
    // WRAP folds back to the span-aligned base once the span end is reached.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] n;
        logic [ADDR_WIDTH-1:0] span;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] inc;
        n    = beat_bytes(size);
        span = n * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        base = addr & ~(span - ADDR_WIDTH'(1));
        inc  = addr + n;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (inc == base + span) ? base : inc;
            default:     next_addr = (addr & ~(n - ADDR_WIDTH'(1))) + n;
        endcase
    endfunction

    // Burst-wide illegality: reserved burst type, beat wider than the bus,
    // or a WRAP with an unsupported length or an unaligned start.
    function automatic logic burst_bad(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] n;
        logic                  len_ok;
        n      = beat_bytes(size);
        len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_bad = (burst == BURST_RSVD) || (size > SIZE_MAX) ||
                    ((burst == BURST_WRAP) &&
                     (!len_ok || ((addr & (n - ADDR_WIDTH'(1))) != '0)));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> OFF) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> OFF);
    endfunction

    // ---------------------------------------------------------------
    // Write engine
    // ---------------------------------------------------------------
    wstate_t               w_state;
    wstate_t               w_next;
    logic                  awready_q;
    logic                  wready_c;
    logic                  bvalid_c;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  w_final;
    logic                  w_we;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_bad;
    logic                  w_err;

    assign wready_c = (w_state == W_DATA);
    assign bvalid_c = (w_state == W_RESP);
    assign aw_hs    = bus.awvalid && awready_q;
    assign w_hs     = bus.wvalid && wready_c;
    assign w_final  = (w_cnt == w_len);
    assign w_we     = w_hs && !w_bad && in_range(w_addr);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // awready is a flop so it only rises on the first edge after reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
        end
    end

    // Burst context; only meaningful between AW acceptance and B completion.
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_len   <= bus.awlen;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
            w_cnt   <= '0;
            w_bad   <= burst_bad(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
            w_err   <= burst_bad(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            // ID or WLAST mismatches only taint the response; data still lands.
            if (!in_range(w_addr) || (bus.wid != w_id) || (bus.wlast != w_final))
                w_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_c;
    assign bus.bvalid  = bvalid_c;
    assign bus.bid     = bvalid_c ? w_id : '0;
    assign bus.bresp   = (bvalid_c && w_err) ? RESP_SLVERR : RESP_OKAY;

    // ---------------------------------------------------------------
    // Read engine
    // ---------------------------------------------------------------
    rstate_t               r_state;
    rstate_t               r_next;
    logic                  arready_q;
    logic                  rvalid_c;
    logic                  ar_hs;
    logic                  r_hs;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_bad;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    // Beat-load selection: the first beat comes straight from the AR
    // channel, later beats from the latched context.
    logic                  ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_len;
    logic [2:0]            ld_size;
    logic [1:0]            ld_burst;
    logic                  ld_bad;
    logic                  ld_last;

    assign rvalid_c = (r_state == R_DATA);
    assign ar_hs    = bus.arvalid && arready_q;
    assign r_hs     = rvalid_c && bus.rready;
    assign ld_en    = ar_hs || (r_hs && !rlast_q);

    always_comb begin
        ld_addr  = r_addr;
        ld_len   = r_len;
        ld_size  = r_size;
        ld_burst = r_burst;
        ld_bad   = r_bad;
        ld_last  = (r_cnt == r_len);
        if (r_state == R_IDLE) begin
            ld_addr  = bus.araddr;
            ld_len   = bus.arlen;
            ld_size  = bus.arsize;
            ld_burst = bus.arburst;
            ld_bad   = burst_bad(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
            ld_last  = (bus.arlen == 8'd0);
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
        end
    end

    // r_cnt holds the number of beats already presented on R.
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_id    <= bus.arid;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_bad   <= ld_bad;
            r_addr  <= next_addr(ld_addr, ld_len, ld_size, ld_burst);
            r_cnt   <= 8'd1;
        end else if (ld_en) begin
            r_addr <= next_addr(ld_addr, ld_len, ld_size, ld_burst);
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    // Output beat register; reads the pre-edge memory word, so a write to
    // the same word on the same edge is not visible in this beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (ld_en) begin
            if (ld_bad || !in_range(ld_addr)) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= mem[word_idx(ld_addr)];
                rresp_q <= RESP_OKAY;
            end
            rlast_q <= ld_last;
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_c;
    assign bus.rid     = rvalid_c ? r_id : '0;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_slv_mem.sv
module tb_axi_slv_mem;
    localparam int AW = 32, DW = 32, IW = 4, DEPTH = 256;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_slv_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_slv_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory, one entry per 32-bit word.
    logic [31:0] model [DEPTH];

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      rq [$];
    bexp_t       bq [$];
    logic [31:0] got_data [$];
    logic [1:0]  got_resp [$];
    logic        got_last [$];
    logic [1:0]  got_bresp;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Address of beat k of a burst, from the burst rules directly.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input logic [1:0] burst, input int k);
        logic [31:0] n, span, base;
        n = 32'd1 << size;
        case (burst)
            2'b00: return start;
            2'b10: begin
                span = n * 32'(len + 1);
                base = start - (start % span);
                return base + ((start - base + 32'(k) * n) % span);
            end
            default: return (k == 0) ? start : (start - (start % n)) + 32'(k) * n;
        endcase
    endfunction

    function automatic bit bad_burst(input logic [31:0] start, input int len, input int size,
                                     input logic [1:0] burst);
        logic [31:0] n;
        n = 32'd1 << size;
        return (burst == 2'b11) || (size > 2) ||
               ((burst == 2'b10) && (!(len inside {1, 3, 7, 15}) || (start % n) != 0));
    endfunction

    task automatic wait_ready(input int ch, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 200) begin
            @(negedge aclk);
            case (ch)
                0:       ok = bus.awready;
                1:       ok = bus.wready;
                2:       ok = bus.arready;
                default: ok = bus.bvalid;
            endcase
            @(posedge aclk);
            #1;
            cyc++;
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst,
                             input logic [31:0] data [16], input logic [3:0] strb [16],
                             input int bad_wid_beat, input int bad_last_beat,
                             input int bdelay, input bit gaps);
        bit          err, bad, ok;
        logic [31:0] a, w;
        bad = bad_burst(addr, len, size, burst);
        err = bad;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = 3'(size); bus.awburst = burst; bus.awvalid = 1'b1;
        wait_ready(0, ok);
        bus.awvalid = 1'b0;
        check("aw_handshake", ok, 1);
        if (!ok) return;
        for (int k = 0; k <= len; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            a = beat_addr(addr, len, size, burst, k);
            w = a >> 2;
            bus.wid    = (k == bad_wid_beat) ? (id ^ 4'h1) : id;
            bus.wdata  = data[k];
            bus.wstrb  = strb[k];
            bus.wlast  = ((k == len) != (k == bad_last_beat));
            bus.wvalid = 1'b1;
            wait_ready(1, ok);
            bus.wvalid = 1'b0;
            check("w_handshake", ok, 1);
            if (!ok) return;
            if (k == bad_wid_beat || k == bad_last_beat || w >= DEPTH) err = 1'b1;
            if (!bad && w < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (strb[k][b]) model[w[7:0]][8*b +: 8] = data[k][8*b +: 8];
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        repeat (bdelay) begin @(posedge aclk); #1; end
        bus.bready = 1'b1;
        wait_ready(3, ok);
        bus.bready = 1'b0;
        check("b_handshake", ok, 1);
        if (!ok) bq.delete();
    endtask

    // rmode: 0 rready always high, 1 random, 2 repeating 1,0,0,1.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, input int rmode);
        bit          bad, ok;
        logic [31:0] a, w;
        int          cyc;
        bad = bad_burst(addr, len, size, burst);
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, len, size, burst, k);
            w = a >> 2;
            if (bad || w >= DEPTH)
                rq.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (k == len)});
            else
                rq.push_back('{id: id, data: model[w[7:0]], resp: 2'b00, last: (k == len)});
        end
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
        bus.arsize = 3'(size); bus.arburst = burst; bus.arvalid = 1'b1;
        wait_ready(2, ok);
        bus.arvalid = 1'b0;
        check("ar_handshake", ok, 1);
        if (!ok) begin rq.delete(); return; end
        cyc = 0;
        while (rq.size() > 0 && cyc < 400) begin
            case (rmode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = 1'($urandom_range(0, 1));
                default: bus.rready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(posedge aclk);
            #1;
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_drain", rq.size(), 0);
        rq.delete();
    endtask

    // Single compare process: every R and B handshake against the model,
    // plus hold-stability while the master stalls.
    rbeat_t     rprev;
    bit         rstall = 1'b0;
    bexp_t      bprev;
    bit         bstall = 1'b0;
    always @(negedge aclk) begin
        rbeat_t cur_r, e;
        bexp_t  cur_b, eb;
        if (areset) begin
            rstall = 1'b0;
            bstall = 1'b0;
        end else begin
            cur_r = '{id: bus.rid, data: bus.rdata, resp: bus.rresp, last: bus.rlast};
            cur_b = '{id: bus.bid, resp: bus.bresp};
            if (rstall) begin
                check("r_hold_valid", bus.rvalid, 1);
                check("r_hold_beat", cur_r, rprev);
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) check("r_unexpected", bus.rvalid, 0);
                else begin
                    e = rq.pop_front();
                    check("r_beat", cur_r, e);
                    got_data.push_back(bus.rdata);
                    got_resp.push_back(bus.rresp);
                    got_last.push_back(bus.rlast);
                end
            end
            rstall = bus.rvalid && !bus.rready;
            rprev  = cur_r;
            if (bstall) begin
                check("b_hold_valid", bus.bvalid, 1);
                check("b_hold_resp", cur_b, bprev);
            end
            if (bus.bvalid) begin
                check("aw_blocked_during_b", bus.awready, 0);
                if (bq.size() == 0) check("b_unexpected", bus.bvalid, 0);
                else if (bus.bready) begin
                    eb = bq.pop_front();
                    check("b_resp", cur_b, eb);
                    got_bresp = bus.bresp;
                end
            end
            bstall = bus.bvalid && !bus.bready;
            bprev  = cur_b;
        end
    end

    function automatic logic [49:0] all_outputs();
        return {bus.awready, bus.wready, bus.bvalid, bus.bid, bus.bresp, bus.arready,
                bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast};
    endfunction

    task automatic fill_full(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = 4'hF;
        end
    endtask

    initial begin
        bit          ok;
        logic [31:0] a0, old2, old3;
        int          size, len, bsel;
        logic [1:0]  burst;
        logic [31:0] addr;

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // Reset state and first-edge awready/arready rise
        repeat (2) @(posedge aclk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("awready_before_edge", {bus.awready, bus.arready}, 2'b00);
        @(posedge aclk);
        #1;
        check("ready_after_edge", {bus.awready, bus.arready}, 2'b11);

        // Model pinning: WRAP beat order and INCR alignment
        check("model_wrap0", beat_addr(32'h38, 3, 2, 2'b10, 0), 32'h38);
        check("model_wrap1", beat_addr(32'h38, 3, 2, 2'b10, 1), 32'h3C);
        check("model_wrap2", beat_addr(32'h38, 3, 2, 2'b10, 2), 32'h30);
        check("model_wrap3", beat_addr(32'h38, 3, 2, 2'b10, 3), 32'h34);
        check("model_incr_unaligned", beat_addr(32'h11, 3, 2, 2'b01, 1), 32'h14);

        // Preload whole memory
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'hF;
            end
            axi_write(4'(b), 32'(b * 64), 15, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        end

        // INCR write/read at 0x10
        fill_full(32'hA0);
        axi_write(4'h5, 32'h10, 3, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        check("incr_bresp", got_bresp, 2'b00);
        check("model_incr_word4", model[4], 32'hA0);
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h5, 32'h10, 3, 2, 2'b01, 0);
        check("incr_rdata", {got_data[0], got_data[1], got_data[2], got_data[3]},
              {32'hA0, 32'hA1, 32'hA2, 32'hA3});
        check("incr_rlast", {got_last[0], got_last[1], got_last[2], got_last[3]}, 4'b0001);

        // WRAP read at 0x38
        fill_full(32'hB0);
        axi_write(4'h2, 32'h30, 3, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h9, 32'h38, 3, 2, 2'b10, 0);
        check("wrap_rdata", {got_data[0], got_data[1], got_data[2], got_data[3]},
              {32'hB2, 32'hB3, 32'hB0, 32'hB1});
        check("wrap_rresp", {got_resp[0], got_resp[1], got_resp[2], got_resp[3]}, 8'h00);

        // Partial strobe
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        axi_write(4'h1, 32'h0, 0, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'b0101;
        axi_write(4'h1, 32'h0, 0, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h1, 32'h0, 0, 2, 2'b01, 0);
        check("strobe_rdata", got_data[0], 32'h11AD33EF);

        // Out-of-range tail
        fill_full(32'hC5);
        axi_write(4'h7, 32'h3FC, 1, 2, 2'b01, wd, ws, -1, -1, 0, 0);
        check("oor_bresp", got_bresp, 2'b10);
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h7, 32'h3FC, 1, 2, 2'b01, 0);
        check("oor_rresp", {got_resp[0], got_resp[1]}, 4'b0010);
        check("oor_rdata", {got_data[0], got_data[1]}, {32'hC5, 32'h0});

        // Illegal burst type, ID mismatch, WLAST mismatch
        fill_full(32'h5A00);
        axi_write(4'h3, 32'h100, 1, 2, 2'b11, wd, ws, -1, -1, 0, 0);
        check("rsvd_bresp", got_bresp, 2'b10);
        axi_read(4'h3, 32'h100, 1, 2, 2'b01, 0);
        axi_write(4'h4, 32'h108, 2, 2, 2'b01, wd, ws, 1, -1, 0, 0);
        check("wid_bresp", got_bresp, 2'b10);
        axi_write(4'h4, 32'h118, 2, 2, 2'b01, wd, ws, -1, 0, 0, 0);
        check("wlast_bresp", got_bresp, 2'b10);
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h4, 32'h108, 5, 2, 2'b01, 0);
        check("wid_data_written", got_data[1], 32'h5A01);
        axi_read(4'h8, 32'h100, 1, 3, 2'b01, 0);

        // Backpressure on R and B
        fill_full(32'hE0);
        axi_write(4'hA, 32'h200, 3, 2, 2'b01, wd, ws, -1, -1, 5, 0);
        axi_read(4'hA, 32'h200, 3, 2, 2'b01, 2);

        // Reset in the middle of a write burst
        old2 = model[8'h22];
        old3 = model[8'h23];
        bus.awid = 4'h3; bus.awaddr = 32'h80; bus.awlen = 8'd3; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        wait_ready(0, ok);
        bus.awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wid = 4'h3; bus.wdata = 32'hC0 + 32'(k); bus.wstrb = 4'hF;
            bus.wlast = 1'b0; bus.wvalid = 1'b1;
            wait_ready(1, ok);
            bus.wvalid = 1'b0;
            model[8'h20 + 8'(k)] = 32'hC0 + 32'(k);
        end
        #2;
        areset = 1'b1;
        #1;
        check("reset_mid_outputs", all_outputs(), 0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("reset_mid_awready_low", bus.awready, 0);
        @(posedge aclk);
        #1;
        check("reset_mid_awready_high", bus.awready, 1);
        repeat (4) @(posedge aclk);
        #1;
        got_data.delete(); got_resp.delete(); got_last.delete();
        axi_read(4'h3, 32'h80, 3, 2, 2'b01, 1);
        check("reset_mid_persist", {got_data[0], got_data[1], got_data[2], got_data[3]},
              {32'hC0, 32'hC1, old2, old3});

        // Randomized traffic, with some concurrent write/read pairs
        for (int it = 0; it < 60; it++) begin
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            bsel = $urandom_range(0, 9);
            burst = (bsel == 0) ? 2'b11 : (bsel < 3) ? 2'b00 : (bsel < 6) ? 2'b10 : 2'b01;
            if (burst == 2'b10) begin
                len = ($urandom_range(0, 7) == 0) ? 2 : (2 << $urandom_range(0, 3)) - 1;
            end else len = $urandom_range(0, 15);
            addr = $urandom_range(0, 1151);
            if (burst == 2'b10 && $urandom_range(0, 5) != 0) addr = addr & ~((32'd1 << size) - 1);
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom);
            end
            if (it % 6 == 5) begin
                a0 = addr % 32'h1C0;
                fork
                    axi_write(4'($urandom), a0, len, size, burst, wd, ws, -1, -1,
                              $urandom_range(0, 3), 1);
                    axi_read(4'($urandom), 32'h200 + a0, len, size, burst, 1);
                join
            end else if ($urandom_range(0, 1) == 0) begin
                axi_write(4'($urandom), addr, len, size, burst, wd, ws,
                          ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1,
                          ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1,
                          $urandom_range(0, 3), 1);
            end else begin
                axi_read(4'($urandom), addr, len, size, burst, 1);
            end
        end

        repeat (5) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
